mux_rr_sched: RTL
=================

# mux_rr_sched

Round-robin scheduler that shares one 8:1 single-bit selection path among eight requesters. It arbitrates `req_pad`, drives the 3-bit select (`sel_pad`) and one-hot grant for the mux, and bounds each grant to a configurable burst length. It also registers the selected data bit as the block's serial output. It sits directly in front of the 8:1 mux/select logic and is its only source of select values.

## Interface
Parameters:
- `BURST`, default 4: maximum cycles per grant; legal range 1..15.

Ports:
- `clk_pad`  in  1: single clock; all logic on its rising edge.
- `rst_pad`  in  1: reset, synchronous, active-high.
- `req_pad`  in  8: request per source; bit n = source n.
- `data_pad`  in  8: data bit per source; bit n = source n.
- `sel_pad`  out  3: mux select, the binary index of the current owner.
- `gnt_pad`  out  8: one-hot grant; all zero when no owner.
- `out_pad`  out  1: registered `data_pad[sel_pad]`.
- `valid_pad`  out  1: `out_pad` carries owner data.
- `lock_pad`  in  1: present only with `MUX_RR_SCHED_LOCK_EN`.

## Operation
- FSM states:
  - IDLE: `gnt_pad` = 0.
  - GRANT: exactly one `gnt_pad` bit is set; `sel_pad` = its index.
- Internal state:
  - `last` (3 bits): index of the most recent owner.
  - `cnt` (4 bits): cycles already spent in the current grant.
- IDLE → GRANT when `req_pad` ≠ 0.
  - Winner = first set `req_pad` bit scanning `last+1`, `last+2`, … modulo 8, wrapping 7→0.
  - On entry: `sel_pad` = winner, `gnt_pad` = 1<<winner, `cnt` = 0, `last` = winner.
- GRANT → IDLE on the first edge where either condition holds:
  - `req_pad[sel_pad]` = 0 (owner withdrew), or
  - `cnt` = BURST−1 (burst exhausted).
- GRANT otherwise: stay and increment `cnt`.
- IDLE always lasts at least one cycle between grants, so consecutive grants are separated by one bubble cycle. A requester never wins twice in a row while another request is pending.
- Data path, registered every cycle:
  - `out_pad` ← `data_pad[sel_pad]` if `gnt_pad` ≠ 0, else 0.
  - `valid_pad` ← (`gnt_pad` ≠ 0).
- Requests arriving or dropping for non-owners during GRANT have no effect until the next IDLE evaluation.
- A sole persistent requester is re-granted after each bubble.

## Timing
- Reset values: `sel_pad` = 0, `gnt_pad` = 0, `out_pad` = 0, `valid_pad` = 0, `cnt` = 0, `last` = 7 (first priority goes to source 0), state = IDLE.
- Reset asserted mid-grant: all of the above apply at the next edge. The grant is dropped without completion and any pending `valid_pad` is cleared.
- Request-to-grant latency: `req_pad` sampled high at edge k in IDLE → `gnt_pad`/`sel_pad` valid after edge k.
- Grant-to-data latency: 1 cycle. `out_pad`/`valid_pad` after edge k+1 reflect `data_pad` sampled at edge k+1 under the select set at edge k.
- Maximum grant length: BURST cycles. `valid_pad` is high for the same number of cycles as `gnt_pad`, delayed by 1.
- Worst-case wait for any continuously requesting source: 7 × (BURST+1) cycles.

## Configuration
- `MUX_RR_SCHED_LOCK_EN` defined:
  - Input `lock_pad` exists.
  - While in GRANT with `lock_pad` = 1 and `req_pad[sel_pad]` = 1, the burst limit is ignored and `cnt` saturates at 15.
  - Release occurs only on owner withdrawal, or on the first cycle with `lock_pad` = 0 and `cnt` ≥ BURST−1.
- Not defined:
  - No `lock_pad` port.
  - The burst limit always applies.

## Test plan
- Reset, then `req_pad` = 0x01 constant, `data_pad[0]` toggling:
  - `gnt_pad` = 0x01 and `sel_pad` = 0 one cycle after reset release.
  - `valid_pad` high one cycle later; `out_pad` tracks `data_pad[0]` with 1-cycle delay.
  - Pattern: 4 grant cycles, 1 bubble, repeat (BURST = 4).
- `req_pad` = 0xFF constant: grant order 0,1,2,…,7,0; each grant lasts 4 cycles followed by 1 IDLE cycle; never two bits set in `gnt_pad`.
- `req_pad` = 0x88 (sources 3 and 7), owner 3 drops `req_pad[3]` after 2 cycles: IDLE next cycle, then `gnt_pad` = 0x80; `valid_pad` low exactly one cycle.
- `rst_pad` pulsed during cycle 2 of a grant to source 5: next cycle all outputs 0; after release with `req_pad` = 0x21, source 0 wins first.
- BURST = 1, `req_pad` = 0x06: grants alternate 0x02, 0x04 with 1-cycle grants and single bubbles.
- With `MUX_RR_SCHED_LOCK_EN`, `lock_pad` = 1 for 10 cycles, `req_pad` = 0x03:
  - Source 0 holds the grant 10 cycles.
  - Releases on the edge after `lock_pad` falls.
  - Next grant is 0x02.

Source files
------------

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler for a shared 8:1 single-bit select path.
// Grants one requester at a time, bounded to BURST cycles, with one idle
// bubble between grants. Also registers the selected data bit as out_pad.
// Optional build macro: MUX_RR_SCHED_LOCK_EN adds lock_pad, which lets the
// current owner hold the grant past the burst limit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no owner, gnt_pad = 0; next requester picked after last_q
// S_GRANT | one owner, gnt_pad one-hot, sel_pad = owner index
module mux_rr_sched #(
   parameter int BURST = 4
) (
   input  logic       clk_pad,
   input  logic       rst_pad,
   input  logic [7:0] req_pad,
   input  logic [7:0] data_pad,
`ifdef MUX_RR_SCHED_LOCK_EN
   input  logic       lock_pad,
`endif
   output logic [2:0] sel_pad,
   output logic [7:0] gnt_pad,
   output logic       out_pad,
   output logic       valid_pad
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

   state_t     state_q, state_d;
   logic [2:0] sel_q,   sel_d;
   logic [7:0] gnt_q,   gnt_d;
   logic [3:0] cnt_q,   cnt_d;
   logic [2:0] last_q,  last_d;
   logic       out_q,   out_d;
   logic       valid_q, valid_d;

   logic       win_found;
   logic [2:0] win_idx;
   logic [2:0] cand;
   logic       owner_req;
   logic       burst_done;
   logic [3:0] cnt_inc;

   // Rotating priority search starting just after the previous owner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      cand      = 3'd0;
      for (int i = 1; i <= 8; i++) begin
         cand = last_q + 3'(i);
         if (!win_found && req_pad[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign owner_req = req_pad[sel_q];

   // Release/increment qualifiers; lock suspends the burst limit and lets
   // the counter saturate so a long hold cannot wrap it back below the limit.
`ifdef MUX_RR_SCHED_LOCK_EN
   always_comb begin
      burst_done = ~lock_pad & (cnt_q >= CNT_LAST);
      cnt_inc    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
   end
`else
   always_comb begin
      burst_done = (cnt_q == CNT_LAST);
      cnt_inc    = cnt_q + 4'd1;
   end
`endif

   // Next-state and grant decode.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            gnt_d = 8'd0;
            if (win_found) begin
               state_d = S_GRANT;
               sel_d   = win_idx;
               gnt_d   = 8'(1) << win_idx;
               cnt_d   = 4'd0;
               last_d  = win_idx;
            end
         end
         S_GRANT: begin
            if (!owner_req || burst_done) begin
               state_d = S_IDLE;
               gnt_d   = 8'd0;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 8'd0;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Data path follows the select registered on the previous edge.
   always_comb begin
      valid_d = |gnt_q;
      out_d   = (|gnt_q) & data_pad[sel_q];
   end

   // State and output registers with synchronous reset; last_q = 7 gives
   // source 0 first priority.
   always_ff @(posedge clk_pad) begin
      if (rst_pad) begin
         state_q <= S_IDLE;
         sel_q   <= 3'd0;
         gnt_q   <= 8'd0;
         cnt_q   <= 4'd0;
         last_q  <= 3'd7;
         out_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign sel_pad   = sel_q;
   assign gnt_pad   = gnt_q;
   assign out_pad   = out_q;
   assign valid_pad = valid_q;

endmodule
